hist_eq_sequencer: RTL and testbench

Top-level phase sequencer for the histogram-equalization datapath. It runs one frame through three stages in order: histogram, CDF, then divider. It drives the one-hot stage enables that steer the shared scratch-memory mux, pulses each stage's start, and waits for that stage's done. It adds a one-cycle guard gap between stages, enforces a per-phase watchdog timeout and reports frame completion or error to the host.

---
 rtl/hist_eq_pkg.sv | 22 ++
 rtl/hist_eq_phase_watchdog.sv | 39 +++
 rtl/hist_eq_sequencer.sv | 120 ++++++++++++
 tb/tb_hist_eq_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_eq_pkg.sv
// rtl/hist_eq_pkg.sv - shared state/phase codes for the histogram-equalization sequencer
package hist_eq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HIST = 3'd1,
    ST_GAP1 = 3'd2,
    ST_CDF  = 3'd3,
    ST_GAP2 = 3'd4,
    ST_DIV  = 3'd5,
    ST_FIN  = 3'd6,
    ST_ERR  = 3'd7
  } state_e;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_HIST = 2'd1;
  localparam logic [1:0] PH_CDF  = 2'd2;
  localparam logic [1:0] PH_DIV  = 2'd3;

  localparam int DEFAULT_TIMEOUT = 65536;

endpackage

// File: rtl/hist_eq_phase_watchdog.sv
// rtl/hist_eq_phase_watchdog.sv - per-phase cycle counter with registered terminal flag
module phase_watchdog
  import hist_eq_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TMO_W   = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] TERM = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] count_q, count_d;
  logic             expired_q;

  always_comb begin
    count_d = count_q;
    if (clear_i)   count_d = '0;
    else if (en_i) count_d = count_q + TMO_W'(1);
  end

  // Flag is computed from the next count so it is high on the cycle the count sits at TERM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= !clear_i && (count_d == TERM);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/hist_eq_sequencer.sv
// rtl/hist_eq_sequencer.sv - HIST -> CDF -> DIV phase sequencer with guard gaps,
// watchdog timeout and frame counting
module hist_eq_sequencer
  import hist_eq_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TMO_W   = 17,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               hist_done,
  input  logic               cdf_done,
  input  logic               div_done,
  output logic               histogram_en,
  output logic               cdf_en,
  output logic               divider_en,
  output logic               hist_start,
  output logic               cdf_start,
  output logic               div_start,
  output logic               busy,
  output logic               frame_done,
  output logic               error,
  output logic [1:0]         err_phase,
  output logic [2:0]         state,
  output logic [FRAME_W-1:0] frame_count
);

  state_e             state_q;
  logic               hist_start_q, cdf_start_q, div_start_q;
  logic               error_q;
  logic [1:0]         err_phase_q;
  logic [FRAME_W-1:0] frame_count_q;
  logic               in_phase, expired;

  assign in_phase = (state_q == ST_HIST) || (state_q == ST_CDF) || (state_q == ST_DIV);

  phase_watchdog #(.TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!in_phase),
    .en_i     (in_phase),
    .expired_o(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hist_start_q  <= 1'b0;
      cdf_start_q   <= 1'b0;
      div_start_q   <= 1'b0;
      error_q       <= 1'b0;
      err_phase_q   <= PH_NONE;
      frame_count_q <= '0;
    end else begin
      hist_start_q <= 1'b0;
      cdf_start_q  <= 1'b0;
      div_start_q  <= 1'b0;
      if (state_q == ST_FIN) frame_count_q <= frame_count_q + FRAME_W'(1);
      // error is only ever set while parked in ERR, so clearing it on any abort is safe
      if (abort) begin
        state_q     <= ST_IDLE;
        error_q     <= 1'b0;
        err_phase_q <= PH_NONE;
      end else begin
        case (state_q)
          ST_IDLE, ST_ERR: if (start) begin
            state_q      <= ST_HIST;
            hist_start_q <= 1'b1;
            error_q      <= 1'b0;
            err_phase_q  <= PH_NONE;
          end
          ST_HIST: if (hist_done) state_q <= ST_GAP1;
                   else if (expired) begin
                     state_q     <= ST_ERR;
                     error_q     <= 1'b1;
                     err_phase_q <= PH_HIST;
                   end
          ST_GAP1: begin
            state_q     <= ST_CDF;
            cdf_start_q <= 1'b1;
          end
          ST_CDF: if (cdf_done) state_q <= ST_GAP2;
                  else if (expired) begin
                    state_q     <= ST_ERR;
                    error_q     <= 1'b1;
                    err_phase_q <= PH_CDF;
                  end
          ST_GAP2: begin
            state_q     <= ST_DIV;
            div_start_q <= 1'b1;
          end
          ST_DIV: if (div_done) state_q <= ST_FIN;
                  else if (expired) begin
                    state_q     <= ST_ERR;
                    error_q     <= 1'b1;
                    err_phase_q <= PH_DIV;
                  end
          ST_FIN: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign histogram_en = (state_q == ST_HIST);
  assign cdf_en       = (state_q == ST_CDF);
  assign divider_en   = (state_q == ST_DIV);
  assign hist_start   = hist_start_q;
  assign cdf_start    = cdf_start_q;
  assign div_start    = div_start_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign frame_done   = (state_q == ST_FIN);
  assign error        = error_q;
  assign err_phase    = err_phase_q;
  assign state        = state_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_hist_eq_sequencer.sv
// tb/tb_hist_eq_sequencer.sv - randomized self-checking bench for hist_eq_sequencer
module tb_hist_eq_sequencer;

  localparam int TMO = 16;
  localparam int FW  = 2;

  logic          clk = 1'b0;
  logic          reset, start, abort, hist_done, cdf_done, div_done;
  logic          histogram_en, cdf_en, divider_en, hist_start, cdf_start, div_start;
  logic          busy, frame_done, error;
  logic [1:0]    err_phase;
  logic [2:0]    state;
  logic [FW-1:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  int fc_model = 0;

  always #5 clk = ~clk;

  hist_eq_sequencer #(.TIMEOUT(TMO), .TMO_W(5), .FRAME_W(FW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .hist_done(hist_done), .cdf_done(cdf_done), .div_done(div_done),
    .histogram_en(histogram_en), .cdf_en(cdf_en), .divider_en(divider_en),
    .hist_start(hist_start), .cdf_start(cdf_start), .div_start(div_start),
    .busy(busy), .frame_done(frame_done), .error(error), .err_phase(err_phase),
    .state(state), .frame_count(frame_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; hist_done = 0; cdf_done = 0; div_done = 0;
  endtask

  function automatic logic [10:0] obs_vec();
    return {state, histogram_en, cdf_en, divider_en, hist_start, cdf_start, div_start, busy, frame_done};
  endfunction

  // Expected state code on cycle c of a frame whose phases last l1+1, l2+1, l3+1 cycles.
  function automatic int exp_state(input int c, input int l1, input int l2, input int l3);
    if (c < 1)                    return 0;
    if (c <= 1 + l1)              return 1;
    if (c == 2 + l1)              return 2;
    if (c <= 3 + l1 + l2)         return 3;
    if (c == 4 + l1 + l2)         return 4;
    if (c <= 5 + l1 + l2 + l3)    return 5;
    if (c == 6 + l1 + l2 + l3)    return 6;
    return 0;
  endfunction

  function automatic logic [10:0] exp_vec(input int es, input int c, input int hs, input int cs, input int ds);
    logic [2:0] s;
    s = 3'(es);
    return {s, es == 1, es == 3, es == 5, c == hs, c == cs, c == ds, (es >= 1 && es <= 6), es == 6};
  endfunction

  task automatic test_reset();
    n_cmp++;
    if ({obs_vec(), error, err_phase, frame_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %b/%b/%b/%b want all zero", obs_vec(), error, err_phase, frame_count);
    end
  endtask

  task automatic test_frame(input int l1, input int l2, input int l3);
    int hs, cs, ds, fin, es;
    logic [10:0] ev, ov;
    hs = 1; cs = 3 + l1; ds = 5 + l1 + l2; fin = 6 + l1 + l2 + l3;
    start = 1;
    for (int c = 1; c <= fin + 1; c++) begin
      tick();
      start = 0;
      es = exp_state(c, l1, l2, l3);
      ev = exp_vec(es, c, hs, cs, ds);
      ov = obs_vec();
      n_cmp++;
      if (ov !== ev) begin
        n_bad++;
        $display("FAIL frame_cycle c=%0d lat=%0d/%0d/%0d: got %b want %b", c, l1, l2, l3, ov, ev);
      end
      hist_done = (c == hs + l1) || (es != 1 && $urandom_range(1) == 1);
      cdf_done  = (c == cs + l2) || (es != 3 && $urandom_range(1) == 1);
      div_done  = (c == ds + l3) || (es != 5 && $urandom_range(1) == 1);
    end
    idle_inputs();
    fc_model = (fc_model + 1) % (1 << FW);
    n_cmp++;
    if ({error, frame_count} !== {1'b0, FW'(fc_model)}) begin
      n_bad++;
      $display("FAIL frame_count: got err=%b cnt=%0d want err=0 cnt=%0d", error, frame_count, fc_model);
    end
  endtask

  task automatic test_back_to_back();
    int cr, es;
    logic [10:0] ev, ov;
    start = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      cr = (c > 7) ? c - 7 : c;
      es = exp_state(cr, 0, 0, 0);
      ev = exp_vec(es, cr, 1, 3, 5);
      ov = obs_vec();
      n_cmp++;
      if (ov !== ev) begin
        n_bad++;
        $display("FAIL back_to_back c=%0d: got %b want %b", c, ov, ev);
      end
      hist_done = (c == 1);
      cdf_done  = (c == 3);
      div_done  = (c == 5);
    end
    idle_inputs();
    abort = 1;
    tick();
    abort = 0;
    fc_model = (fc_model + 1) % (1 << FW);
    n_cmp++;
    if ({obs_vec(), frame_count} !== {11'b0, FW'(fc_model)}) begin
      n_bad++;
      $display("FAIL back_to_back_abort: got %b cnt=%0d want 0 cnt=%0d", obs_vec(), frame_count, fc_model);
    end
  endtask

  task automatic test_timeout(input int ph);
    int l1, e, pst;
    l1  = $urandom_range(4);
    e   = (ph == 1) ? 1 : 3 + l1;
    pst = (ph == 1) ? 1 : 3;
    start = 1;
    for (int c = 1; c <= e + TMO; c++) begin
      tick();
      start = 0;
      if (c >= e && c <= e + TMO - 1) begin
        n_cmp++;
        if ({state, error} !== {3'(pst), 1'b0}) begin
          n_bad++;
          $display("FAIL timeout_phase ph=%0d c=%0d: got st=%0d err=%b want st=%0d err=0", ph, c, state, error, pst);
        end
      end
      if (c == e + TMO) begin
        n_cmp++;
        if ({state, error, err_phase, histogram_en, cdf_en, divider_en, busy} !== {3'd7, 1'b1, 2'(ph), 4'b0}) begin
          n_bad++;
          $display("FAIL timeout_err ph=%0d: got st=%0d err=%b ph=%0d en=%b%b%b busy=%b want st=7 err=1 ph=%0d en=000 busy=0",
                   ph, state, error, err_phase, histogram_en, cdf_en, divider_en, busy, ph);
        end
      end
      hist_done = (ph == 2) && (c == 1 + l1);
    end
    hist_done = 0;
    for (int i = 0; i < 3; i++) begin
      hist_done = $urandom_range(1) == 1;
      cdf_done  = $urandom_range(1) == 1;
      div_done  = $urandom_range(1) == 1;
      tick();
      n_cmp++;
      if ({state, error, err_phase} !== {3'd7, 1'b1, 2'(ph)}) begin
        n_bad++;
        $display("FAIL err_sticky ph=%0d: got st=%0d err=%b ph=%0d", ph, state, error, err_phase);
      end
    end
    idle_inputs();
    if (ph == 2) begin
      start = 1;
      tick();
      start = 0;
      n_cmp++;
      if ({state, error, err_phase, hist_start} !== {3'd1, 1'b0, 2'd0, 1'b1}) begin
        n_bad++;
        $display("FAIL err_restart: got st=%0d err=%b ph=%0d hs=%b want st=1 err=0 ph=0 hs=1", state, error, err_phase, hist_start);
      end
    end
    abort = 1;
    tick();
    abort = 0;
    n_cmp++;
    if ({state, error, err_phase, busy, frame_count} !== {3'd0, 1'b0, 2'd0, 1'b0, FW'(fc_model)}) begin
      n_bad++;
      $display("FAIL err_abort ph=%0d: got st=%0d err=%b ph=%0d busy=%b cnt=%0d", ph, state, error, err_phase, busy, frame_count);
    end
  endtask

  task automatic test_abort();
    int k;
    k = $urandom_range(5, 1);
    start = 1;
    for (int c = 1; c <= k; c++) begin
      tick();
      start = 0;
      n_cmp++;
      if (state !== 3'd1) begin
        n_bad++;
        $display("FAIL abort_pre c=%0d: got st=%0d want 1", c, state);
      end
    end
    abort = 1;
    hist_done = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_inputs();
      n_cmp++;
      if ({obs_vec(), frame_count} !== {11'b0, FW'(fc_model)}) begin
        n_bad++;
        $display("FAIL abort_idle i=%0d: got %b cnt=%0d want 0 cnt=%0d", i, obs_vec(), frame_count, fc_model);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    start = 1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 0;
      hist_done = (c == 1);
      cdf_done  = (c == 3);
    end
    idle_inputs();
    n_cmp++;
    if ({state, divider_en} !== {3'd5, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_pre_div: got st=%0d den=%b want st=5 den=1", state, divider_en);
    end
    #2 reset = 1;
    #1;
    n_cmp++;
    if ({obs_vec(), error, err_phase, frame_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got %b/%b/%b/%b want all zero", obs_vec(), error, err_phase, frame_count);
    end
    tick();
    reset = 0;
    fc_model = 0;
  endtask

  task automatic test_counter_wrap();
    int exp_seq[5];
    exp_seq = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      test_frame($urandom_range(3), $urandom_range(3), $urandom_range(3));
      n_cmp++;
      if (frame_count !== FW'(exp_seq[i])) begin
        n_bad++;
        $display("FAIL counter_wrap i=%0d: got %0d want %0d", i, frame_count, exp_seq[i]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    test_reset();
    test_frame(10, 10, 10);
    test_back_to_back();
    for (int i = 0; i < 4; i++)
      test_frame($urandom_range(TMO - 1), $urandom_range(TMO - 1), $urandom_range(TMO - 1));
    test_frame(TMO - 1, TMO - 1, TMO - 1);
    test_frame(0, 0, 0);
    test_timeout(2);
    test_timeout(1);
    test_abort();
    test_reset_mid_div();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
